// File: rtl/exu_pkg.sv
// Shared encodings for the RV64IM execute unit: ALU opcodes, operand-2
// sources and ctrl_ex bit positions.
package exu_pkg;

    localparam int XLEN      = 64;
    localparam int CTRL_EX_W = 11;

    localparam int CTRL_EX_NPCSRC  = 10;
    localparam int CTRL_EX_WORD    = 9;
    localparam int CTRL_EX_ADDSRC  = 8;
    localparam int CTRL_EX_ALUSRC1 = 7;
    localparam int ALUSRC2_MSB     = 6;
    localparam int ALUSRC2_LSB     = 5;
    localparam int ALUOP_MSB       = 4;
    localparam int ALUOP_LSB       = 0;

    localparam logic [1:0] SRC2_RS2  = 2'd0;
    localparam logic [1:0] SRC2_IMM  = 2'd1;
    localparam logic [1:0] SRC2_FOUR = 2'd2;
    localparam logic [1:0] SRC2_CSR  = 2'd3;

    localparam logic [4:0] ALU_ADD    = 5'd0;
    localparam logic [4:0] ALU_SUB    = 5'd1;
    localparam logic [4:0] ALU_AND    = 5'd2;
    localparam logic [4:0] ALU_OR     = 5'd3;
    localparam logic [4:0] ALU_XOR    = 5'd4;
    localparam logic [4:0] ALU_SLL    = 5'd5;
    localparam logic [4:0] ALU_SRL    = 5'd6;
    localparam logic [4:0] ALU_SRA    = 5'd7;
    localparam logic [4:0] ALU_SLT    = 5'd8;
    localparam logic [4:0] ALU_SLTU   = 5'd9;
    localparam logic [4:0] ALU_EQ     = 5'd10;
    localparam logic [4:0] ALU_NE     = 5'd11;
    localparam logic [4:0] ALU_GE     = 5'd12;
    localparam logic [4:0] ALU_GEU    = 5'd13;
    localparam logic [4:0] ALU_MUL    = 5'd14;
    localparam logic [4:0] ALU_MULH   = 5'd15;
    localparam logic [4:0] ALU_MULHSU = 5'd16;
    localparam logic [4:0] ALU_MULHU  = 5'd17;
    localparam logic [4:0] ALU_DIV    = 5'd18;
    localparam logic [4:0] ALU_DIVU   = 5'd19;
    localparam logic [4:0] ALU_REM    = 5'd20;
    localparam logic [4:0] ALU_REMU   = 5'd21;
    localparam logic [4:0] ALU_ANDN   = 5'd22;
    localparam logic [4:0] ALU_PASS2  = 5'd23;

endpackage

// File: rtl/rv64_exu_if.sv
// ID/EX operand bundle into the execute unit and its result/dnpc back out.
// master drives operands (parent pipeline), slave is the execute unit.
interface rv64_exu_if;
    import exu_pkg::*;

    logic [CTRL_EX_W-1:0] ctrl_ex;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      rs1data;
    logic [XLEN-1:0]      rs2data;
    logic [XLEN-1:0]      csrdata;
    logic [XLEN-1:0]      imm;
    logic [XLEN-1:0]      dnpc;
    logic [XLEN-1:0]      result;

    modport master (
        output ctrl_ex, pc, rs1data, rs2data, csrdata, imm,
        input  dnpc, result
    );

    modport slave (
        input  ctrl_ex, pc, rs1data, rs2data, csrdata, imm,
        output dnpc, result
    );

endinterface

// File: rtl/exu_muldiv.sv
// Combinational M-extension datapath. Operands arrive already extended for
// word mode, so a 64-bit operation here yields the correct 32-bit low half.
module exu_muldiv
    import exu_pkg::*;
(
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] res
);

    logic         a_sx;
    logic         b_sx;
    logic [127:0] prod;
    logic         div0;
    logic         ovf;
    logic [63:0]  q_s;
    logic [63:0]  r_s;

    // One truncated 128x128 multiply covers all signedness combinations
    assign a_sx = (op == ALU_MULH) || (op == ALU_MULHSU);
    assign b_sx = (op == ALU_MULH);
    assign prod = {{64{a_sx & a[63]}}, a} * {{64{b_sx & b[63]}}, b};

    assign div0 = (b == '0);
    assign ovf  = (a == 64'h8000_0000_0000_0000) && (&b);
    assign q_s  = $signed(a) / $signed(b);
    assign r_s  = $signed(a) % $signed(b);

    always_comb begin
        res = '0;
        unique case (op)
            ALU_MUL:    res = prod[63:0];
            ALU_MULH,
            ALU_MULHSU,
            ALU_MULHU:  res = prod[127:64];
            ALU_DIV:    res = div0 ? '1 : (ovf ? a : q_s);
            ALU_DIVU:   res = div0 ? '1 : a / b;
            ALU_REM:    res = div0 ? a : (ovf ? '0 : r_s);
            ALU_REMU:   res = div0 ? a : a % b;
            default:    res = '0;
        endcase
    end

endmodule

// File: rtl/rv64_exu.sv
// Combinational execute stage: ALU result and next-PC candidate.
// Define RV64_EXU_MULDIV_EN to include the M-extension multiplier/divider.
module rv64_exu
    import exu_pkg::*;
(
    input logic       clk,
    input logic       rst,
    rv64_exu_if.slave bus
);

    logic            npc_src;
    logic            word;
    logic            add_src;
    logic            src1;
    logic [1:0]      src2;
    logic [4:0]      op;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            uns;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [5:0]      sh;
    logic [XLEN-1:0] r;
    logic [XLEN-1:0] sum;
    logic            unused_ok;

    assign unused_ok = &{1'b0, clk, rst};

    assign npc_src = bus.ctrl_ex[CTRL_EX_NPCSRC];
    assign word    = bus.ctrl_ex[CTRL_EX_WORD];
    assign add_src = bus.ctrl_ex[CTRL_EX_ADDSRC];
    assign src1    = bus.ctrl_ex[CTRL_EX_ALUSRC1];
    assign src2    = bus.ctrl_ex[ALUSRC2_MSB:ALUSRC2_LSB];
    assign op      = bus.ctrl_ex[ALUOP_MSB:ALUOP_LSB];

    assign op1 = src1 ? bus.pc : bus.rs1data;

    always_comb begin
        op2 = bus.rs2data;
        unique case (src2)
            SRC2_RS2:  op2 = bus.rs2data;
            SRC2_IMM:  op2 = bus.imm;
            SRC2_FOUR: op2 = 64'd4;
            SRC2_CSR:  op2 = bus.csrdata;
            default:   op2 = bus.rs2data;
        endcase
    end

    // Word mode: narrow to 32 bits, extend per the op's signedness
    assign uns = (op == ALU_SRL)  || (op == ALU_SLTU) ||
                 (op == ALU_GEU)  || (op == ALU_MULHU) ||
                 (op == ALU_DIVU) || (op == ALU_REMU);

    assign a = !word ? op1 :
               uns ? {32'b0, op1[31:0]} : {{32{op1[31]}}, op1[31:0]};
    assign b = !word ? op2 :
               uns ? {32'b0, op2[31:0]} : {{32{op2[31]}}, op2[31:0]};
    assign sh = word ? {1'b0, op2[4:0]} : op2[5:0];

`ifdef RV64_EXU_MULDIV_EN
    logic [XLEN-1:0] md_res;

    exu_muldiv u_muldiv (
        .op  (op),
        .a   (a),
        .b   (b),
        .res (md_res)
    );
`endif

    always_comb begin
        r = '0;
        unique case (op)
            ALU_ADD:   r = a + b;
            ALU_SUB:   r = a - b;
            ALU_AND:   r = a & b;
            ALU_OR:    r = a | b;
            ALU_XOR:   r = a ^ b;
            ALU_SLL:   r = a << sh;
            ALU_SRL:   r = a >> sh;
            ALU_SRA:   r = $signed(a) >>> sh;
            ALU_SLT:   r = {63'b0, $signed(a) < $signed(b)};
            ALU_SLTU:  r = {63'b0, a < b};
            ALU_EQ:    r = {63'b0, a == b};
            ALU_NE:    r = {63'b0, a != b};
            ALU_GE:    r = {63'b0, $signed(a) >= $signed(b)};
            ALU_GEU:   r = {63'b0, a >= b};
`ifdef RV64_EXU_MULDIV_EN
            ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
            ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU:
                       r = md_res;
`endif
            ALU_ANDN:  r = b & ~a;
            ALU_PASS2: r = b;
            default:   r = '0;
        endcase
    end

    assign bus.result = word ? {{32{r[31]}}, r[31:0]} : r;

    // JALR clears bit 0 of the target; branches/JAL use pc + imm as is
    assign sum      = (add_src ? bus.rs1data : bus.pc) + bus.imm;
    assign bus.dnpc = npc_src ? bus.csrdata :
                      add_src ? {sum[63:1], 1'b0} : sum;

endmodule

// File: tb/tb_rv64_exu.sv
// Directed self-checking bench for rv64_exu.
// Build with +define+RV64_EXU_MULDIV_EN to exercise the M-extension.
module tb_rv64_exu;
    import exu_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    rv64_exu_if bus ();

    rv64_exu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] cw(
        input logic npc, input logic w, input logic adds,
        input logic s1, input logic [1:0] s2, input logic [4:0] op);
        return {npc, w, adds, s1, s2, op};
    endfunction

    task automatic drive(
        input logic [10:0] c, input logic [63:0] pc,
        input logic [63:0] r1, input logic [63:0] r2,
        input logic [63:0] csr, input logic [63:0] imm);
        @(negedge clk);
        bus.ctrl_ex = c;
        bus.pc      = pc;
        bus.rs1data = r1;
        bus.rs2data = r2;
        bus.csrdata = csr;
        bus.imm     = imm;
        #2;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive('0, '0, '0, '0, '0, '0);
        n_checks++;
        if (bus.result !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_result: got %h want %h", bus.result, 64'd0);
        end
        n_checks++;
        if (bus.dnpc !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_dnpc: got %h want %h", bus.dnpc, 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_alu;
        logic [63:0] exp;
        drive(cw(0,0,0,0,SRC2_IMM,ALU_ADD), 0, 64'd5, 64'd7, 0, -64'sd3);
        n_checks++;
        if (bus.result !== 64'd2) begin
            n_fail++;
            $display("FAIL add_imm: got %h want %h", bus.result, 64'd2);
        end
        drive(cw(0,0,0,0,SRC2_RS2,ALU_SUB), 0, 64'd5, 64'd7, 0, -64'sd3);
        exp = 64'hFFFF_FFFF_FFFF_FFFE;
        n_checks++;
        if (bus.result !== exp) begin
            n_fail++;
            $display("FAIL sub: got %h want %h", bus.result, exp);
        end
        drive(cw(0,0,0,0,SRC2_RS2,ALU_SLL), 0, 64'd1, 64'd63, 0, 0);
        exp = 64'h8000_0000_0000_0000;
        n_checks++;
        if (bus.result !== exp) begin
            n_fail++;
            $display("FAIL sll63: got %h want %h", bus.result, exp);
        end
        drive(cw(0,0,0,0,SRC2_RS2,ALU_XOR), 0, 64'hF0F0, 64'h0FF0, 0, 0);
        n_checks++;
        if (bus.result !== 64'hFF00) begin
            n_fail++;
            $display("FAIL xor: got %h want %h", bus.result, 64'hFF00);
        end
        drive(cw(0,0,0,0,SRC2_CSR,ALU_ANDN), 0, 64'h0F, 0, 64'hFF, 0);
        n_checks++;
        if (bus.result !== 64'hF0) begin
            n_fail++;
            $display("FAIL andn: got %h want %h", bus.result, 64'hF0);
        end
        drive(cw(0,0,0,0,SRC2_RS2,5'd24), 0, 64'd9, 64'd9, 0, 0);
        n_checks++;
        if (bus.result !== 64'd0) begin
            n_fail++;
            $display("FAIL op24: got %h want %h", bus.result, 64'd0);
        end
    endtask

    task automatic test_branch;
        drive(cw(0,0,0,0,SRC2_RS2,ALU_GE), 64'h8000_0000, '1, 64'd1, 0, 64'h10);
        n_checks++;
        if (bus.result !== 64'd0) begin
            n_fail++;
            $display("FAIL ge: got %h want %h", bus.result, 64'd0);
        end
        n_checks++;
        if (bus.dnpc !== 64'h8000_0010) begin
            n_fail++;
            $display("FAIL br_dnpc: got %h want %h", bus.dnpc, 64'h8000_0010);
        end
        drive(cw(0,0,0,0,SRC2_RS2,ALU_GEU), 64'h8000_0000, '1, 64'd1, 0, 64'h10);
        n_checks++;
        if (bus.result !== 64'd1) begin
            n_fail++;
            $display("FAIL geu: got %h want %h", bus.result, 64'd1);
        end
        drive(cw(0,0,0,0,SRC2_RS2,ALU_SLT), 0, '1, 64'd1, 0, 0);
        n_checks++;
        if (bus.result !== 64'd1) begin
            n_fail++;
            $display("FAIL slt: got %h want %h", bus.result, 64'd1);
        end
        drive(cw(0,0,0,0,SRC2_RS2,ALU_EQ), 0, 64'd42, 64'd42, 0, 0);
        n_checks++;
        if (bus.result !== 64'd1) begin
            n_fail++;
            $display("FAIL eq: got %h want %h", bus.result, 64'd1);
        end
    endtask

    task automatic test_jalr;
        drive(cw(0,0,1,1,SRC2_FOUR,ALU_ADD), 64'h8000_0100,
              64'h8000_0005, 0, 0, 64'h2);
        n_checks++;
        if (bus.dnpc !== 64'h8000_0006) begin
            n_fail++;
            $display("FAIL jalr_dnpc: got %h want %h", bus.dnpc, 64'h8000_0006);
        end
        n_checks++;
        if (bus.result !== 64'h8000_0104) begin
            n_fail++;
            $display("FAIL link: got %h want %h", bus.result, 64'h8000_0104);
        end
    endtask

    task automatic test_word;
        logic [63:0] exp;
        drive(cw(0,1,0,0,SRC2_IMM,ALU_SRL), 0,
              64'hFFFF_FFFF_8000_0000, 0, 0, 64'd4);
        n_checks++;
        if (bus.result !== 64'h0000_0000_0800_0000) begin
            n_fail++;
            $display("FAIL srlw: got %h want %h", bus.result, 64'h0800_0000);
        end
        drive(cw(0,1,0,0,SRC2_IMM,ALU_SRA), 0,
              64'hFFFF_FFFF_8000_0000, 0, 0, 64'd4);
        exp = 64'hFFFF_FFFF_F800_0000;
        n_checks++;
        if (bus.result !== exp) begin
            n_fail++;
            $display("FAIL sraw: got %h want %h", bus.result, exp);
        end
        drive(cw(0,1,0,0,SRC2_IMM,ALU_ADD), 0, 64'h7FFF_FFFF, 0, 0, 64'd1);
        exp = 64'hFFFF_FFFF_8000_0000;
        n_checks++;
        if (bus.result !== exp) begin
            n_fail++;
            $display("FAIL addw: got %h want %h", bus.result, exp);
        end
        drive(cw(0,1,0,0,SRC2_IMM,ALU_SLL), 0, 64'h1, 0, 0, 64'd36);
        n_checks++;
        if (bus.result !== 64'h10) begin
            n_fail++;
            $display("FAIL sllw: got %h want %h", bus.result, 64'h10);
        end
    endtask

    task automatic test_muldiv;
        logic [63:0] exp;
        logic [63:0] mn;
        mn = 64'h8000_0000_0000_0000;
`ifdef RV64_EXU_MULDIV_EN
        drive(cw(0,0,0,0,SRC2_RS2,ALU_DIV), 0, 64'd5, 64'd0, 0, 0);
        n_checks++;
        if (bus.result !== '1) begin
            n_fail++;
            $display("FAIL div0: got %h want %h", bus.result, 64'hFFFF_FFFF_FFFF_FFFF);
        end
        drive(cw(0,0,0,0,SRC2_RS2,ALU_REMU), 0, 64'd7, 64'd0, 0, 0);
        n_checks++;
        if (bus.result !== 64'd7) begin
            n_fail++;
            $display("FAIL remu0: got %h want %h", bus.result, 64'd7);
        end
        drive(cw(0,0,0,0,SRC2_RS2,ALU_DIV), 0, mn, '1, 0, 0);
        n_checks++;
        if (bus.result !== mn) begin
            n_fail++;
            $display("FAIL div_ovf: got %h want %h", bus.result, mn);
        end
        drive(cw(0,0,0,0,SRC2_RS2,ALU_REM), 0, mn, '1, 0, 0);
        n_checks++;
        if (bus.result !== 64'd0) begin
            n_fail++;
            $display("FAIL rem_ovf: got %h want %h", bus.result, 64'd0);
        end
        drive(cw(0,0,0,0,SRC2_RS2,ALU_MULHU), 0, mn, 64'd2, 0, 0);
        n_checks++;
        if (bus.result !== 64'd1) begin
            n_fail++;
            $display("FAIL mulhu: got %h want %h", bus.result, 64'd1);
        end
        drive(cw(0,0,0,0,SRC2_RS2,ALU_MUL), 0, 64'd3, -64'sd4, 0, 0);
        exp = 64'hFFFF_FFFF_FFFF_FFF4;
        n_checks++;
        if (bus.result !== exp) begin
            n_fail++;
            $display("FAIL mul: got %h want %h", bus.result, exp);
        end
        drive(cw(0,0,0,0,SRC2_RS2,ALU_MULH), 0, '1, 64'd2, 0, 0);
        n_checks++;
        if (bus.result !== '1) begin
            n_fail++;
            $display("FAIL mulh: got %h want %h", bus.result, 64'hFFFF_FFFF_FFFF_FFFF);
        end
        drive(cw(0,1,0,0,SRC2_RS2,ALU_DIV), 0, 64'h8000_0000, '1, 0, 0);
        exp = 64'hFFFF_FFFF_8000_0000;
        n_checks++;
        if (bus.result !== exp) begin
            n_fail++;
            $display("FAIL divw_ovf: got %h want %h", bus.result, exp);
        end
        drive(cw(0,0,0,0,SRC2_RS2,ALU_DIVU), 0, 64'd100, 64'd7, 0, 0);
        n_checks++;
        if (bus.result !== 64'd14) begin
            n_fail++;
            $display("FAIL divu: got %h want %h", bus.result, 64'd14);
        end
`else
        drive(cw(0,0,0,0,SRC2_RS2,ALU_DIV), 0, 64'd100, 64'd7, 0, 0);
        n_checks++;
        if (bus.result !== 64'd0) begin
            n_fail++;
            $display("FAIL div_off: got %h want %h", bus.result, 64'd0);
        end
        drive(cw(0,0,0,0,SRC2_RS2,ALU_MUL), 0, mn, 64'd3, 0, 0);
        n_checks++;
        if (bus.result !== 64'd0) begin
            n_fail++;
            $display("FAIL mul_off: got %h want %h", bus.result, 64'd0);
        end
`endif
    endtask

    task automatic test_trap;
        drive(cw(1,0,0,0,SRC2_CSR,ALU_PASS2), 64'h1234, 64'h55, 0,
              64'h8000_1000, 64'h40);
        n_checks++;
        if (bus.dnpc !== 64'h8000_1000) begin
            n_fail++;
            $display("FAIL trap_dnpc: got %h want %h", bus.dnpc, 64'h8000_1000);
        end
        n_checks++;
        if (bus.result !== 64'h8000_1000) begin
            n_fail++;
            $display("FAIL pass2: got %h want %h", bus.result, 64'h8000_1000);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        test_reset();
        test_alu();
        test_branch();
        test_jalr();
        test_word();
        test_muldiv();
        test_trap();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
